t05_tree_node_builder: RTL and testbench
========================================

T05_TREE_NODE_BUILDER -- requirements
Module: t05_tree_node_builder

Interface
REQ-001 SHALL have ports: clk  in  1  system clock; single clock domain.
REQ-002 SHALL have ports: rst  in  1  reset, asynchronous, active-high.
REQ-003 SHALL have ports: flv_fin  in  1  least-value search finished; the least1/least2/sum inputs are stable.
REQ-004 SHALL have ports: least1, least2  in  9  node tags; bit8=0 means leaf char[7:0], bit8=1 means internal node[6:0]; 9'h180 means NULL.
REQ-005 SHALL have ports: sum  in  64  combined weight of least1 and least2.
REQ-006 SHALL have ports: mem_wr  out  1, mem_addr  out  10, mem_wdata  out  64, mem_busy  in  1; SRAM write port.
REQ-007 SHALL have ports: flv_restart  out  1  one-cycle pulse requesting a new least-value pass.
REQ-008 SHALL have ports: HTREE_complete  out  1  one-cycle pulse when the tree is finished.
REQ-009 SHALL have ports: root  out  9  root tag, valid from HTREE_complete onward.
REQ-010 SHALL have ports: node_count  out  8  number of internal nodes created.
REQ-011 SHALL have ports: err  out  1  sticky error flag (empty histogram or node overflow).

Function
REQ-012 Memory map SHALL be: histogram at 0-255; sum table at 256+n for n 0-127; node table at 512+n.
REQ-013 Tag-to-address mapping SHALL be: leaf tag -> {2'b00, tag[7:0]}; internal tag -> 256 + tag[6:0].
REQ-014 States SHALL be IDLE, LATCH, WR_NODE, WR_SUM, WIPE1, WIPE2, RESTART, DONE.
REQ-015 IDLE: when flv_fin=1, the block SHALL go to LATCH and capture least1, least2 and sum into internal registers.
REQ-016 LATCH, case least1=NULL: go to DONE, set err, root=NULL.
REQ-017 LATCH, case least2=NULL: go to DONE, root=least1.
REQ-018 LATCH, case node_count=128: go to DONE, set err, root=NULL.
REQ-019 LATCH, all other cases: go to WR_NODE.
REQ-020 WR_NODE SHALL write addr=512+node_count, data={46'b0, least1, least2}.
REQ-021 WR_SUM SHALL write addr=256+node_count, data=latched sum.
REQ-022 WIPE1 SHALL write data 0 to addr(least1); WIPE2 SHALL write data 0 to addr(least2). This removes consumed nodes from later passes.
REQ-023 A write SHALL be accepted on any cycle with mem_wr=1 and mem_busy=0. mem_addr and mem_wdata SHALL hold stable while mem_busy=1. The FSM SHALL advance only on acceptance.
REQ-024 mem_wr SHALL be 1 exactly in WR_NODE, WR_SUM, WIPE1 and WIPE2; mem_addr and mem_wdata SHALL be 0 elsewhere.
REQ-025 On leaving WIPE2, node_count SHALL increment (8-bit, saturating at 128). The FSM SHALL then go to RESTART.
REQ-026 RESTART SHALL assert flv_restart for one cycle, then go to IDLE.
REQ-027 DONE entry SHALL assert HTREE_complete for one cycle. DONE SHALL hold, ignoring flv_fin, until reset.
REQ-028 flv_fin asserted outside IDLE SHALL be ignored.
REQ-029 With mem_busy=0, latency from flv_fin to flv_restart SHALL be 6 cycles (IDLE->LATCH->4 writes->RESTART).

Reset
REQ-030 On rst=1 the block SHALL asynchronously enter IDLE with mem_wr=0, mem_addr=0, mem_wdata=0, flv_restart=0, HTREE_complete=0, root=9'h180, node_count=0, err=0, and latched registers cleared.
REQ-031 Reset asserted mid-write SHALL drop mem_wr in the same cycle; the partial pass is discarded.

Structure
REQ-032 A shared package t05_pkg SHALL hold: the NULL_TAG constant (9'h180), the HIST_BASE, SUM_BASE and NODE_BASE constants, MAX_NODES (128), and the FSM state enum.
REQ-033 The block SHALL be a single module with no sub-module; the tag-to-address mapping SHALL be a package function.

Verification
REQ-034 Scenario: least1=9'h041, least2=9'h042, sum=5, mem_busy=0 -> writes in order (512, {..,041,042}), (256, 5), (65, 0), (66, 0); flv_restart pulses 6 cycles after flv_fin; node_count=1.
REQ-035 Scenario: least1=9'h100, least2=9'h043 with node_count=3 -> node write at 515; wipes at 256 and 67.
REQ-036 Scenario: least2=9'h180, least1=9'h102 -> no writes; HTREE_complete pulses once; root=9'h102; err=0.
REQ-037 Scenario: least1=least2=9'h180 -> HTREE_complete pulses; err=1; root=9'h180.
REQ-038 Scenario: mem_busy held 1 for 3 cycles during WR_SUM -> addr 256+n and its data held stable; one write accepted; total latency 9 cycles.
REQ-039 Scenario: rst pulsed during WIPE1 -> all outputs return to reset values; a subsequent flv_fin restarts at node_count=0.

Source files
------------

// File: rtl/t05_pkg.sv
// Shared constants, FSM state type and tag-to-address helper for the Huffman
// tree node builder.
package t05_pkg;

    localparam logic [8:0] NULL_TAG  = 9'h180;
    localparam logic [9:0] HIST_BASE = 10'd0;
    localparam logic [9:0] SUM_BASE  = 10'd256;
    localparam logic [9:0] NODE_BASE = 10'd512;
    localparam logic [7:0] MAX_NODES = 8'd128;

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        WR_NODE,
        WR_SUM,
        WIPE1,
        WIPE2,
        RESTART,
        DONE
    } state_t;

    // Leaves live in the histogram, internal nodes in the sum table.
    function automatic logic [9:0] tagAddr(input logic [8:0] tag);
        if (tag[8]) begin
            tagAddr = SUM_BASE + {3'b000, tag[6:0]};
        end else begin
            tagAddr = HIST_BASE + {2'b00, tag[7:0]};
        end
    endfunction

endpackage

// File: rtl/t05_tree_node_builder.sv
// Builds one Huffman tree node per least-value pass: records the node and its
// weight in SRAM, zeroes the two consumed entries, then asks for a new pass.
module t05_tree_node_builder
    import t05_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        flv_fin,
    input  logic [8:0]  least1,
    input  logic [8:0]  least2,
    input  logic [63:0] sum,
    output logic        mem_wr,
    output logic [9:0]  mem_addr,
    output logic [63:0] mem_wdata,
    input  logic        mem_busy,
    output logic        flv_restart,
    output logic        HTREE_complete,
    output logic [8:0]  root,
    output logic [7:0]  node_count,
    output logic        err
);

    state_t      state_q, state_d;
    logic [8:0]  least1_q, least1_d;
    logic [8:0]  least2_q, least2_d;
    logic [63:0] sum_q, sum_d;
    logic [7:0]  nodeCount_q, nodeCount_d;
    logic [8:0]  root_q, root_d;
    logic        err_q, err_d;
    logic        htreeComplete_q, htreeComplete_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= IDLE;
            least1_q        <= '0;
            least2_q        <= '0;
            sum_q           <= '0;
            nodeCount_q     <= '0;
            root_q          <= NULL_TAG;
            err_q           <= 1'b0;
            htreeComplete_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            least1_q        <= least1_d;
            least2_q        <= least2_d;
            sum_q           <= sum_d;
            nodeCount_q     <= nodeCount_d;
            root_q          <= root_d;
            err_q           <= err_d;
            htreeComplete_q <= htreeComplete_d;
        end
    end

    // Memory outputs come straight from state and latched tags, so they stay
    // put while the SRAM stalls and vanish at once when reset hits.
    always_comb begin
        state_d         = state_q;
        least1_d        = least1_q;
        least2_d        = least2_q;
        sum_d           = sum_q;
        nodeCount_d     = nodeCount_q;
        root_d          = root_q;
        err_d           = err_q;
        htreeComplete_d = 1'b0;
        mem_wr          = 1'b0;
        mem_addr        = '0;
        mem_wdata       = '0;
        flv_restart     = 1'b0;

        case (state_q)
            IDLE: begin
                if (flv_fin) begin
                    state_d  = LATCH;
                    least1_d = least1;
                    least2_d = least2;
                    sum_d    = sum;
                end
            end
            LATCH: begin
                if (least1_q == NULL_TAG) begin
                    state_d         = DONE;
                    err_d           = 1'b1;
                    root_d          = NULL_TAG;
                    htreeComplete_d = 1'b1;
                end else if (least2_q == NULL_TAG) begin
                    state_d         = DONE;
                    root_d          = least1_q;
                    htreeComplete_d = 1'b1;
                end else if (nodeCount_q == MAX_NODES) begin
                    state_d         = DONE;
                    err_d           = 1'b1;
                    root_d          = NULL_TAG;
                    htreeComplete_d = 1'b1;
                end else begin
                    state_d = WR_NODE;
                end
            end
            WR_NODE: begin
                mem_wr    = 1'b1;
                mem_addr  = NODE_BASE + {2'b00, nodeCount_q};
                mem_wdata = {46'b0, least1_q, least2_q};
                if (!mem_busy) state_d = WR_SUM;
            end
            WR_SUM: begin
                mem_wr    = 1'b1;
                mem_addr  = SUM_BASE + {2'b00, nodeCount_q};
                mem_wdata = sum_q;
                if (!mem_busy) state_d = WIPE1;
            end
            WIPE1: begin
                mem_wr   = 1'b1;
                mem_addr = tagAddr(least1_q);
                if (!mem_busy) state_d = WIPE2;
            end
            WIPE2: begin
                mem_wr   = 1'b1;
                mem_addr = tagAddr(least2_q);
                if (!mem_busy) begin
                    state_d = RESTART;
                    if (nodeCount_q < MAX_NODES) nodeCount_d = nodeCount_q + 8'd1;
                end
            end
            RESTART: begin
                flv_restart = 1'b1;
                state_d     = IDLE;
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign HTREE_complete = htreeComplete_q;
    assign root           = root_q;
    assign node_count     = nodeCount_q;
    assign err            = err_q;

endmodule

// File: tb/tb_t05_tree_node_builder.sv
// Randomized self-checking bench for the tree node builder against a
// pass-level reference model.
module tb_t05_tree_node_builder;

    localparam logic [8:0] NULL = 9'h180;

    logic        clk = 1'b0;
    logic        rst;
    logic        flv_fin;
    logic [8:0]  least1;
    logic [8:0]  least2;
    logic [63:0] sum;
    logic        mem_wr;
    logic [9:0]  mem_addr;
    logic [63:0] mem_wdata;
    logic        mem_busy;
    logic        flv_restart;
    logic        HTREE_complete;
    logic [8:0]  root;
    logic [7:0]  node_count;
    logic        err;

    int testsRun = 0;
    int testsFailed = 0;

    int cyc = 0;
    int startCyc, restartCyc, restartHigh, completeHigh, wIdx, expBusy;
    int busyPlan[4];
    bit holding;
    logic [9:0]  holdAddr;
    logic [63:0] holdData;
    logic [9:0]  wAddr[$];
    logic [63:0] wData[$];

    int mCount;
    bit mErr, mDone;
    logic [8:0] mRoot;

    t05_tree_node_builder dut (
        .clk            (clk),
        .rst            (rst),
        .flv_fin        (flv_fin),
        .least1         (least1),
        .least2         (least2),
        .sum            (sum),
        .mem_wr         (mem_wr),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_busy       (mem_busy),
        .flv_restart    (flv_restart),
        .HTREE_complete (HTREE_complete),
        .root           (root),
        .node_count     (node_count),
        .err            (err)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Where a tag lives in memory: leaves by char code, internal nodes in the sum table.
    function automatic int modelAddr(input logic [8:0] tag);
        int t;
        t = int'(tag);
        return (t >= 256) ? 256 + (t % 128) : t;
    endfunction

    function automatic logic [8:0] randTag();
        if ($urandom_range(0, 1) == 1) return 9'(256 + $urandom_range(0, 127));
        return 9'($urandom_range(0, 255));
    endfunction

    function automatic int randBusy();
        if ($urandom_range(0, 3) == 0) return int'($urandom_range(1, 2));
        return 0;
    endfunction

    // One clock: observe outputs on the falling edge, play the SRAM (stall per
    // the busy plan, log accepted writes), then return just after the rising edge.
    task automatic stepCycle();
        @(negedge clk);
        if (!rst) begin
            if (flv_restart) begin
                restartHigh++;
                restartCyc = cyc;
            end
            if (HTREE_complete) completeHigh++;
            if (mem_wr) begin
                if (holding) begin
                    checkOutput("heldAddr", 64'(mem_addr), 64'(holdAddr));
                    checkOutput("heldData", mem_wdata, holdData);
                end
                if (wIdx < 4 && busyPlan[wIdx] > 0) begin
                    busyPlan[wIdx]--;
                    mem_busy = 1'b1;
                    holding  = 1'b1;
                    holdAddr = mem_addr;
                    holdData = mem_wdata;
                end else begin
                    mem_busy = 1'b0;
                    holding  = 1'b0;
                    wAddr.push_back(mem_addr);
                    wData.push_back(mem_wdata);
                    wIdx++;
                end
            end else begin
                holding  = 1'b0;
                mem_busy = 1'($urandom_range(0, 1));
                checkOutput("idleAddr", 64'(mem_addr), 64'd0);
                checkOutput("idleData", mem_wdata, 64'd0);
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Asynchronous reset: outputs must be back at reset values right away.
    task automatic doReset();
        rst      = 1'b1;
        flv_fin  = 1'b0;
        mem_busy = 1'b0;
        holding  = 1'b0;
        #1;
        checkOutput("rstMemWr", 64'(mem_wr), 64'd0);
        checkOutput("rstAddr", 64'(mem_addr), 64'd0);
        checkOutput("rstData", mem_wdata, 64'd0);
        checkOutput("rstRestart", 64'(flv_restart), 64'd0);
        checkOutput("rstComplete", 64'(HTREE_complete), 64'd0);
        checkOutput("rstRoot", 64'(root), 64'(NULL));
        checkOutput("rstCount", 64'(node_count), 64'd0);
        checkOutput("rstErr", 64'(err), 64'd0);
        stepCycle();
        stepCycle();
        rst    = 1'b0;
        mCount = 0;
        mErr   = 1'b0;
        mDone  = 1'b0;
        mRoot  = NULL;
    endtask

    // Runs one least-value pass and checks it against the model's view of
    // what that pass should do.
    task automatic applyStimulus(input logic [8:0] l1, input logic [8:0] l2, input logic [63:0] s,
                                 input int b0, input int b1, input int b2, input int b3);
        int waitCnt;
        int eAddr[4];
        logic [63:0] eData[4];
        busyPlan[0] = b0;
        busyPlan[1] = b1;
        busyPlan[2] = b2;
        busyPlan[3] = b3;
        expBusy = b0 + b1 + b2 + b3;
        wAddr.delete();
        wData.delete();
        wIdx = 0;
        holding = 1'b0;
        restartHigh = 0;
        completeHigh = 0;
        restartCyc = 0;

        least1 = l1;
        least2 = l2;
        sum = s;
        flv_fin = 1'b1;
        startCyc = cyc;
        stepCycle();
        flv_fin = 1'b0;
        least1 = randTag();
        least2 = randTag();
        sum = {$urandom, $urandom};
        waitCnt = 0;
        while (restartHigh == 0 && completeHigh == 0 && waitCnt < 40) begin
            flv_fin = (waitCnt == 2);
            stepCycle();
            waitCnt++;
        end
        flv_fin = 1'b0;
        repeat (3) stepCycle();

        if (mDone) begin
            checkOutput("ignWrites", 64'(wAddr.size()), 64'd0);
            checkOutput("ignRestart", 64'(restartHigh), 64'd0);
            checkOutput("ignComplete", 64'(completeHigh), 64'd0);
            checkOutput("ignRoot", 64'(root), 64'(mRoot));
            checkOutput("ignErr", 64'(err), 64'(mErr));
        end else if (l1 == NULL || l2 == NULL || mCount == 128) begin
            mDone = 1'b1;
            if (l1 != NULL && l2 == NULL) begin
                mRoot = l1;
            end else begin
                mRoot = NULL;
                mErr = 1'b1;
            end
            checkOutput("endWrites", 64'(wAddr.size()), 64'd0);
            checkOutput("endComplete", 64'(completeHigh), 64'd1);
            checkOutput("endRestart", 64'(restartHigh), 64'd0);
            checkOutput("endRoot", 64'(root), 64'(mRoot));
            checkOutput("endErr", 64'(err), 64'(mErr));
            checkOutput("endCount", 64'(node_count), 64'(mCount));
        end else begin
            eAddr[0] = 512 + mCount;
            eAddr[1] = 256 + mCount;
            eAddr[2] = modelAddr(l1);
            eAddr[3] = modelAddr(l2);
            eData[0] = 64'(l1) * 64'd512 + 64'(l2);
            eData[1] = s;
            eData[2] = 64'd0;
            eData[3] = 64'd0;
            mCount++;
            checkOutput("numWrites", 64'(wAddr.size()), 64'd4);
            for (int i = 0; i < 4; i++) begin
                if (i < wAddr.size()) begin
                    checkOutput($sformatf("wrAddr%0d", i), 64'(wAddr[i]), 64'(eAddr[i]));
                    checkOutput($sformatf("wrData%0d", i), wData[i], eData[i]);
                end
            end
            checkOutput("restartPulse", 64'(restartHigh), 64'd1);
            checkOutput("noComplete", 64'(completeHigh), 64'd0);
            checkOutput("latency", 64'(restartCyc - startCyc), 64'(6 + expBusy));
            checkOutput("nodeCount", 64'(node_count), 64'(mCount));
            checkOutput("errClear", 64'(err), 64'd0);
        end
    endtask

    // Directed scenarios first, then random passes until the node table fills.
    initial begin
        int waitCnt;
        logic [8:0] t1, t2;
        rst = 1'b1;
        flv_fin = 1'b0;
        mem_busy = 1'b0;
        least1 = '0;
        least2 = '0;
        sum = '0;
        @(posedge clk);
        #1;
        doReset();

        applyStimulus(9'h041, 9'h042, 64'd5, 0, 0, 0, 0);

        // Reset while the first wipe is on the bus.
        t1 = randTag();
        t2 = randTag();
        busyPlan = '{0, 0, 0, 0};
        wAddr.delete();
        wData.delete();
        wIdx = 0;
        holding = 1'b0;
        least1 = t1;
        least2 = t2;
        sum = {$urandom, $urandom};
        flv_fin = 1'b1;
        stepCycle();
        flv_fin = 1'b0;
        waitCnt = 0;
        while (!(wIdx == 2 && mem_wr) && waitCnt < 20) begin
            stepCycle();
            waitCnt++;
        end
        checkOutput("reachWipe1", 64'(mem_addr), 64'(modelAddr(t1)));
        doReset();

        repeat (3) applyStimulus(randTag(), randTag(), {$urandom, $urandom}, 0, 0, 0, 0);
        applyStimulus(9'h100, 9'h043, 64'd77, 0, 0, 0, 0);
        applyStimulus(randTag(), randTag(), {$urandom, $urandom}, 0, 3, 0, 0);

        while (mCount < 128) begin
            applyStimulus(randTag(), randTag(), {$urandom, $urandom},
                          randBusy(), randBusy(), randBusy(), randBusy());
        end
        applyStimulus(randTag(), randTag(), {$urandom, $urandom}, 0, 0, 0, 0);
        applyStimulus(randTag(), randTag(), {$urandom, $urandom}, 0, 0, 0, 0);

        doReset();
        applyStimulus(randTag(), randTag(), {$urandom, $urandom}, 1, 0, 2, 0);
        applyStimulus(9'h102, NULL, 64'd9, 0, 0, 0, 0);
        applyStimulus(9'h010, 9'h011, 64'd3, 0, 0, 0, 0);

        doReset();
        applyStimulus(NULL, NULL, 64'd0, 0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
